// File: rtl/uart_rx_stream_if.sv
// Byte stream carrying received UART data from the receiver to its downstream sink.
interface uart_rx_stream_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_stream.sv
// Oversampling 8N1 UART receiver presenting bytes on a valid/ready stream.
// Define UART_RX_PARITY_EN to receive a parity bit (sense set by PARITY_ODD).
module uart_rx_stream #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  uart_rx_stream_if.master stream,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             parity_err
);

  localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCNT_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
  localparam logic [TCNT_W-1:0] TICK_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);

  if (DIV < 1) begin : g_bad_div
    $fatal(1, "uart_rx_stream: CLK_FREQ / (BAUD_RATE * OVERSAMPLE) must be >= 1");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
    $fatal(1, "uart_rx_stream: OVERSAMPLE must be even and >= 8");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
    $fatal(1, "uart_rx_stream: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic              r_sync1;
  logic              r_sync2;
  logic              w_rx_s;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [TCNT_W-1:0] r_tick_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              w_tick;
  logic              w_tcnt_mid;
  logic              w_tcnt_last;
  logic              w_tcnt_clr;
  logic              w_shift_en;
  logic              w_commit;
  logic              w_ferr;
  logic [7:0]        r_data;
  logic              r_valid;
  logic              r_frame_err;
  logic              r_overrun_err;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Divider is held clear while idle so the first tick lands DIV clocks after the start edge.
  assign w_tick      = (r_state != S_IDLE) && (r_div_cnt == DIV_LAST);
  assign w_tcnt_mid  = w_tick && (r_tick_cnt == TICK_MID);
  assign w_tcnt_last = w_tick && (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tcnt_clr) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= r_tick_cnt + TCNT_W'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  logic w_par_sample;
  logic w_par_mismatch;
  logic r_par_bad;
  logic r_parity_err;

  assign w_par_mismatch = w_rx_s ^ (^r_shift) ^ PAR_ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_sample & w_par_mismatch;
      if (r_state == S_IDLE) begin
        r_par_bad <= 1'b0;
      end else if (w_par_sample) begin
        r_par_bad <= w_par_mismatch;
      end
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_commit    = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_sample = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_tcnt_clr = 1'b1;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tcnt_mid) begin
          w_tcnt_clr  = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tcnt_last) begin
          w_tcnt_clr = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_tcnt_last) begin
          w_tcnt_clr   = 1'b1;
          w_par_sample = 1'b1;
          w_state_nxt  = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_tcnt_last) begin
          w_tcnt_clr = 1'b1;
          if (w_rx_s) begin
`ifdef UART_RX_PARITY_EN
            w_commit = ~r_par_bad;
`else
            w_commit = 1'b1;
`endif
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_en) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
      end
    end
  end

  // A commit coinciding with a handshake refills the holding register instead of overrunning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_frame_err   <= w_ferr;
      r_overrun_err <= w_commit & r_valid & ~stream.ready;
      if (w_commit && (!r_valid || stream.ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && stream.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign stream.data  = r_data;
  assign stream.valid = r_valid;
  assign frame_err    = r_frame_err;
  assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed and randomized frame-level checks of uart_rx_stream against a byte/event model.
module tb_uart_rx_stream;

  localparam int CLK_FREQ   = 100000000;
  localparam int BAUD_RATE  = 1000000;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
  localparam int BIT        = (CLK_FREQ / (BAUD_RATE * OVERSAMPLE)) * OVERSAMPLE;

  logic clk;
  logic rst_n;
  logic rxd;
  logic frame_err;
  logic overrun_err;
  logic parity_err;

  uart_rx_stream_if u_if ();

  uart_rx_stream #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd         (rxd),
    .stream      (u_if),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rx_q[$];
  int n_valid_cyc = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_pe = 0;
  int n_wide = 0;
  int n_unstable = 0;
  logic prev_fe = 1'b0;
  logic prev_ov = 1'b0;
  logic prev_pe = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  // Observes the sink side: accepted bytes, error pulses, pulse widths and data stability.
  always @(negedge clk) begin
    if (u_if.valid && u_if.ready) rx_q.push_back(u_if.data);
    if (u_if.valid) n_valid_cyc++;
    if (frame_err) n_fe++;
    if (overrun_err) n_ov++;
    if (parity_err) n_pe++;
    if ((frame_err && prev_fe) || (overrun_err && prev_ov) || (parity_err && prev_pe)) n_wide++;
    if (prev_hold && u_if.valid && (u_if.data !== prev_data)) n_unstable++;
    prev_fe   = frame_err;
    prev_ov   = overrun_err;
    prev_pe   = parity_err;
    prev_hold = u_if.valid && !u_if.ready;
    prev_data = u_if.data;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_rx();
    if (rx_q.size() == 0) return 32'hDEAD_BEEF;
    return {24'h0, rx_q.pop_front()};
  endfunction

  task automatic send_bit(input logic b, input int n);
    rxd = b;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
    send_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ (PARITY_ODD != 0) ^ par_flip, BIT);
`else
    if (par_flip) $display("note: parity not compiled in, flip ignored");
`endif
    send_bit(stop_v, BIT);
    rxd = 1'b1;
  endtask

  int fe0, ov0, vc0, pe0, exp_fe;
  logic [7:0] exp_q[$];
  logic [7:0] rb;
  logic bad;

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    u_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", u_if.valid, 0);
    check("rst_data", u_if.data, 8'h00);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun_err", overrun_err, 0);
    check("rst_parity_err", parity_err, 0);
    rst_n = 1'b1;
    send_bit(1'b1, 2 * BIT);

    // Single byte, sink always ready
    fe0 = n_fe; ov0 = n_ov; vc0 = n_valid_cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    check("a5_count", rx_q.size(), 1);
    check("a5_data", pop_rx(), 8'hA5);
    check("a5_valid_cycles", n_valid_cyc - vc0, 1);
    check("a5_no_fe", n_fe - fe0, 0);
    check("a5_no_ov", n_ov - ov0, 0);

    // Three back-to-back bytes with the sink stalled: first held, two overruns
    u_if.ready = 1'b0;
    fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    check("ovr_valid_held", u_if.valid, 1);
    check("ovr_data_held", u_if.data, 8'h00);
    check("ovr_pulses", n_ov - ov0, 2);
    check("ovr_none_taken", rx_q.size(), 0);
    check("ovr_no_fe", n_fe - fe0, 0);
    u_if.ready = 1'b1;
    send_bit(1'b1, 2);
    check("ovr_valid_cleared", u_if.valid, 0);
    check("ovr_one_handshake", rx_q.size(), 1);
    check("ovr_taken_data", pop_rx(), 8'h00);
    send_bit(1'b1, BIT);

    // Framing error followed by a held-low break, then a clean byte
    fe0 = n_fe; ov0 = n_ov;
    send_frame(8'h3C, 1'b0, 1'b0);
    send_bit(1'b0, 2 * BIT);
    send_bit(1'b1, BIT);
    send_frame(8'h12, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    check("fe_pulses", n_fe - fe0, 1);
    check("fe_count", rx_q.size(), 1);
    check("fe_next_data", pop_rx(), 8'h12);
    check("fe_no_ov", n_ov - ov0, 0);

    // Short low glitch must read as a false start
    fe0 = n_fe; ov0 = n_ov; vc0 = n_valid_cyc;
    send_bit(1'b0, 30);
    send_bit(1'b1, 2 * BIT);
    check("glitch_no_valid", n_valid_cyc - vc0, 0);
    check("glitch_no_errs", (n_fe - fe0) + (n_ov - ov0), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    check("glitch_next_data", pop_rx(), 8'h81);

    // Reset in the middle of bit 4 of 0xF0 abandons the frame silently
    fe0 = n_fe; ov0 = n_ov;
    send_bit(1'b0, BIT);
    for (int i = 0; i < 4; i++) send_bit(1'b0, BIT);
    send_bit(1'b1, BIT / 2);
    rst_n = 1'b0;
    send_bit(1'b1, 3);
    rst_n = 1'b1;
    check("midrst_valid", u_if.valid, 0);
    check("midrst_data", u_if.data, 8'h00);
    send_bit(1'b1, BIT - BIT / 2 - 3);
    send_bit(1'b1, 4 * BIT);
    check("midrst_nothing", rx_q.size(), 0);
    send_frame(8'h81, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    check("midrst_next_data", pop_rx(), 8'h81);
    check("midrst_no_errs", (n_fe - fe0) + (n_ov - ov0), 0);

    // Random bytes with occasional bad stop bits
    fe0 = n_fe; exp_fe = 0;
    for (int k = 0; k < 10; k++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(rb, !bad, 1'b0);
      if (bad) begin
        exp_fe++;
        send_bit(1'b1, BIT);
      end else begin
        exp_q.push_back(rb);
      end
      send_bit(1'b1, $urandom_range(0, 1) * BIT);
    end
    send_bit(1'b1, BIT);
    check("rand_count", rx_q.size(), exp_q.size());
    check("rand_fe", n_fe - fe0, exp_fe);
    for (int i = 0; i < exp_q.size(); i++) check("rand_data", pop_rx(), exp_q[i]);

`ifdef UART_RX_PARITY_EN
    pe0 = n_pe; vc0 = n_valid_cyc;
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1, BIT);
    check("par_bad_pulse", n_pe - pe0, 1);
    check("par_bad_no_valid", n_valid_cyc - vc0, 0);
    pe0 = n_pe;
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1, BIT);
    check("par_good_data", pop_rx(), 8'h07);
    check("par_good_no_pulse", n_pe - pe0, 0);
`else
    pe0 = 0;
    check("par_tied_low", n_pe - pe0, 0);
`endif

    check("pulse_width", n_wide, 0);
    check("data_stable", n_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
